// File: rtl/serial_add_seq.sv
// ---------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial adder sequencer.  A single 1-bit full adder (two half adders and
// an OR) is reused over WIDTH clocks to add two WIDTH-bit operands, LSB
// first, with a carry flop linking successive bits.
//
// Optional feature macro: SERIAL_SUB_EN
//   When defined, 'sub' selects A-B (two's complement: B inverted and the
//   carry seeded with 1).  When undefined, 'sub' is ignored and the block
//   always computes A+B.
//
// Parameters:
//   WIDTH  operand/result width, 2..16
//   CNT_W  bit-index counter width, 2**CNT_W >= WIDTH
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   start    in   request a new operation (accepted only in IDLE)
//   op_a     in   operand A, captured on the accepting edge
//   op_b     in   operand B, captured on the accepting edge
//   sub      in   subtract select (SERIAL_SUB_EN builds only)
//   busy     out  high while bits are being computed
//   done     out  one-cycle pulse, sum/cout valid
//   sum      out  registered result, held until next completion
//   cout     out  registered carry out of the MSB
//   bit_idx  out  index of bit in progress, 0 outside RUN
// ---------------------------------------------------------------------------
module serial_add_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CNT_W-1:0] bit_idx
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    // Operand B and carry seed as loaded on the accepting edge
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_init;

`ifdef SERIAL_SUB_EN
    assign w_b_load = sub ? ~op_b : op_b;
    assign w_c_init = sub;
`else
    logic               w_sub_unused;
    assign w_sub_unused = sub;
    assign w_b_load     = op_b;
    assign w_c_init     = 1'b0;
`endif

    // Shared full adder: two half adders plus an OR for the carry
    logic w_p;
    logic w_g1;
    logic w_s;
    logic w_g2;
    logic w_carry_next;

    assign w_p          = r_sh_a[0] ^ r_sh_b[0];
    assign w_g1         = r_sh_a[0] & r_sh_b[0];
    assign w_s          = w_p ^ r_carry;
    assign w_g2         = w_p & r_carry;
    assign w_carry_next = w_g1 | w_g2;

    // Result fills from the top so it is LSB-aligned after WIDTH shifts
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    assign w_res_next = {w_s, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        bit_idx = '0;
        case (r_state)
            ST_RUN: begin
                busy    = 1'b1;
                bit_idx = r_cnt;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sh_a  <= '0;
            r_sh_b  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sh_a  <= op_a;
                        r_sh_b  <= w_b_load;
                        r_carry <= w_c_init;
                        r_cnt   <= '0;
                        r_res   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_carry <= w_carry_next;
                    r_res   <= w_res_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    // Publish only on the final bit so sum/cout stay stable during RUN
                    if (w_last) begin
                        r_sum  <= w_res_next;
                        r_cout <= w_carry_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CNT_W-1:0] bit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] prev_sum;
    logic             prev_cout;

    serial_add_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .sub     (sub),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .bit_idx (bit_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation: accept, WIDTH busy cycles, DONE, back to IDLE.
    // With poke=1, extra starts are raised mid-RUN and during DONE.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic poke);
        int n_done;
        n_done = 0;
        start = 1'b1; op_a = a; op_b = b; sub = s;
        tick();                                   // accepting edge E0
        start = 1'b0;
        op_a = ~a; op_b = a ^ 8'h5A; sub = ~s;    // operands free to change now
        for (int i = 0; i < WIDTH; i++) begin
            check({tag, " busy"}, 32'(busy), 32'd1);
            check({tag, " bit_idx"}, 32'(bit_idx), 32'(i));
            check({tag, " no_done"}, 32'(done), 32'd0);
            check({tag, " sum_held"}, 32'(sum), 32'(prev_sum));
            check({tag, " cout_held"}, 32'(cout), 32'(prev_cout));
            if (poke && i == 3) begin
                start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy_in_done"}, 32'(busy), 32'd0);
        check({tag, " bit_idx_done"}, 32'(bit_idx), 32'd0);
        check({tag, " sum"}, 32'(sum), 32'(exp_sum));
        check({tag, " cout"}, 32'(cout), 32'(exp_cout));
        if (done) n_done++;
        if (poke) begin
            start = 1'b1; op_a = 8'hAA; op_b = 8'h55;
        end
        tick();                                   // back to IDLE
        start = 1'b0;
        check({tag, " idle_no_done"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        tick();                                   // start in DONE must not have been taken
        check({tag, " stay_idle"}, 32'(busy), 32'd0);
        check({tag, " sum_keep"}, 32'(sum), 32'(exp_sum));
        $display("%s: A=0x%02h B=0x%02h sub=%0d -> sum=0x%02h cout=%0d (expect 0x%02h/%0d) dones=%0d",
                 tag, a, b, s, sum, cout, exp_sum, exp_cout, n_done);
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; op_a = 8'h12; op_b = 8'h34; sub = 1'b0;
        prev_sum = '0; prev_cout = 1'b0;

        // Reset wins over a simultaneous start
        tick(); tick();
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst bit_idx", 32'(bit_idx), 32'd0);
        $display("reset: busy=%0d done=%0d sum=0x%02h cout=%0d bit_idx=%0d", busy, done, sum, cout, bit_idx);
        start = 1'b0; rst_n = 1'b1;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        run_op("add_25_13", 8'h25, 8'h13, 1'b0, 8'h38, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("ignore_start", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);

        // Abort mid-RUN with reset at bit_idx=4
        start = 1'b1; op_a = 8'h80; op_b = 8'h80;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort bit_idx", 32'(bit_idx), 32'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(done), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort cout", 32'(cout), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("abort no_done", 32'(done), 32'd0);
            tick();
        end
        $display("abort: busy=%0d sum=0x%02h cout=%0d", busy, sum, cout);
        prev_sum = '0; prev_cout = 1'b0;
        run_op("add_01_02", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Back-to-back with start held high; one op every 10 cycles
        start = 1'b1; op_a = 8'h10; op_b = 8'h20;
        tick();
        for (int t = 0; t < 30; t++) begin
            check("b2b done", 32'(done), 32'((t % 10) == 8));
            check("b2b busy", 32'(busy), 32'((t % 10) < 8));
            if ((t % 10) < 8) check("b2b bit_idx", 32'(bit_idx), 32'(t % 10));
            if (t >= 8) begin
                check("b2b sum", 32'(sum), 32'h30);
                check("b2b cout", 32'(cout), 32'd0);
            end
            if (done) $display("b2b: t=%0d sum=0x%02h cout=%0d", t, sum, cout);
            if ((t % 10) >= 1 && (t % 10) <= 6) begin
                op_a = 8'(t * 7); op_b = ~8'(t);
            end else begin
                op_a = 8'h10; op_b = 8'h20;
            end
            if (t == 29) start = 1'b0;
            tick();
        end
        check("b2b stopped", 32'(busy), 32'd0);
        prev_sum = 8'h30; prev_cout = 1'b0;

`ifdef SERIAL_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0);
        run_op("sub0_add", 8'h70, 8'h90, 1'b0, 8'h00, 1'b1, 1'b0);
`else
        run_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0);
        run_op("sub_01_02", 8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 1'b0);
        run_op("sub0_add", 8'h70, 8'h90, 1'b0, 8'h00, 1'b1, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
